// File: rtl/vedic_pkg.sv
// vedic_pkg
// Shared constants and elaboration helpers for the pipelined Vedic multiplier.
//   VEDIC_LATENCY : number of register stages between operand and product
//   pw(w)         : product width for a w-bit operand pair
//   vedic_width_ok: legal operand widths are powers of two from 8 to 64
// Optional feature macro used by the files that import this package:
//   VEDIC_SIGNED_EN (adds two's-complement operand mode)
`default_nettype none

package vedic_pkg;

   localparam int VEDIC_LATENCY = 3;
   localparam int VEDIC_MIN_WIDTH = 8;
   localparam int VEDIC_MAX_WIDTH = 64;

   function automatic int pw(input int w);
      return 2 * w;
   endfunction

   function automatic bit vedic_width_ok(input int w);
      return (w >= VEDIC_MIN_WIDTH) && (w <= VEDIC_MAX_WIDTH) && ((w & (w - 1)) == 0);
   endfunction

endpackage

`default_nettype wire

// File: rtl/vedic_mult_pipe_if.sv
// vedic_mult_pipe_if
// Operand/product handshake bundle for vedic_mult_pipe.
//   in_valid/in_ready   : operand pair handshake (a, b travel with it)
//   out_valid/out_ready : product handshake (y travels with it)
//   sign_mode           : only with VEDIC_SIGNED_EN, treats a and b as two's complement
// Modports: master = producer/consumer side (testbench), slave = multiplier side.
`default_nettype none

interface vedic_mult_pipe_if
   import vedic_pkg::*;
#(
   parameter int WIDTH = 16
);

   logic                    in_valid;
   logic                    in_ready;
   logic [WIDTH-1:0]        a;
   logic [WIDTH-1:0]        b;
`ifdef VEDIC_SIGNED_EN
   logic                    sign_mode;
`endif
   logic                    out_valid;
   logic                    out_ready;
   logic [pw(WIDTH)-1:0]    y;

   modport master (
`ifdef VEDIC_SIGNED_EN
      output sign_mode,
`endif
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, y
   );

   modport slave (
`ifdef VEDIC_SIGNED_EN
      input  sign_mode,
`endif
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, y
   );

endinterface

`default_nettype wire

// File: rtl/vedic_nxn.sv
// vedic_nxn
// Combinational recursive Urdhva-Tiryagbhyam multiplier, N x N -> 2N unsigned.
// Each level splits both operands into halves, forms the four half-width
// cross products with smaller instances of itself and recombines them.
// The recursion bottoms out at N = 2 with an AND/half-adder cell.
//   i_a, i_b : N-bit operands
//   o_p      : 2N-bit product
`default_nettype none

module vedic_nxn #(
   parameter int N = 8
) (
   input  logic [N-1:0]   i_a,
   input  logic [N-1:0]   i_b,
   output logic [2*N-1:0] o_p
);

   if (N == 2) begin : g_leaf
      logic w_p00, w_p01, w_p10, w_p11;
      logic w_c1;

      assign w_p00 = i_a[0] & i_b[0];
      assign w_p01 = i_a[0] & i_b[1];
      assign w_p10 = i_a[1] & i_b[0];
      assign w_p11 = i_a[1] & i_b[1];

      // Two half adders: the cross terms give bit 1, their carry joins the top term.
      assign w_c1  = w_p01 & w_p10;
      assign o_p   = {w_p11 & w_c1, w_p11 ^ w_c1, w_p01 ^ w_p10, w_p00};
   end else begin : g_split
      localparam int H = N / 2;

      logic [N-1:0] w_ll, w_lh, w_hl, w_hh;
      logic [N:0]   w_mid;

      vedic_nxn #(.N(H)) u_ll (.i_a(i_a[H-1:0]), .i_b(i_b[H-1:0]), .o_p(w_ll));
      vedic_nxn #(.N(H)) u_lh (.i_a(i_a[H-1:0]), .i_b(i_b[N-1:H]), .o_p(w_lh));
      vedic_nxn #(.N(H)) u_hl (.i_a(i_a[N-1:H]), .i_b(i_b[H-1:0]), .o_p(w_hl));
      vedic_nxn #(.N(H)) u_hh (.i_a(i_a[N-1:H]), .i_b(i_b[N-1:H]), .o_p(w_hh));

      // The cross sum keeps its carry so it reaches the upper product half.
      assign w_mid = {1'b0, w_lh} + {1'b0, w_hl};
      assign o_p   = {w_hh, w_ll} + ({{(N-1){1'b0}}, w_mid} << H);
   end

endmodule

`default_nettype wire

// File: rtl/vedic_mult_pipe.sv
// vedic_mult_pipe
// Pipelined WIDTH x WIDTH -> 2*WIDTH Vedic multiplier with valid/ready on both sides.
//   S1: registered operands (magnitudes and product sign when signed mode exists)
//   S2: four HALF x HALF partial products
//   S3: recombined product
// The whole pipe advances together whenever the last stage is empty or being
// drained, so one product per cycle flows with downstream ready held high.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   io_bus     : vedic_mult_pipe_if slave (in_valid/in_ready/a/b, out_valid/out_ready/y)
// Optional feature macro: VEDIC_SIGNED_EN (adds io_bus.sign_mode, two's-complement operands)
`default_nettype none

module vedic_mult_pipe
   import vedic_pkg::*;
#(
   parameter  int WIDTH = 16,
   localparam int HALF  = WIDTH / 2
) (
   input  logic              clk,
   input  logic              rst_n,
   vedic_mult_pipe_if.slave  io_bus
);

   if (!vedic_width_ok(WIDTH)) begin : g_bad_width
      $error("vedic_mult_pipe: WIDTH must be a power of two between 8 and 64");
   end

   logic                   w_en;
   logic [WIDTH-1:0]       w_aIn;
   logic [WIDTH-1:0]       w_bIn;
   logic                   w_negIn;
   logic [WIDTH-1:0]       w_ll, w_lh, w_hl, w_hh;
   logic [WIDTH:0]         w_mid;
   logic [pw(WIDTH)-1:0]   w_prod;
   logic [pw(WIDTH)-1:0]   w_y;

   logic                   r_v1, r_v2, r_v3;
   logic [WIDTH-1:0]       r_a, r_b;
   logic                   r_neg1, r_neg2;
   logic [WIDTH-1:0]       r_ll, r_lh, r_hl, r_hh;
   logic [pw(WIDTH)-1:0]   r_y;

   // Whole-pipe stall: everything moves only when the output slot can be vacated.
   assign w_en            = !r_v3 || io_bus.out_ready;
   assign io_bus.in_ready = w_en;

   // Signed mode converts operands to magnitudes up front so the multiplier
   // core stays unsigned; the product sign rides along to the last stage.
`ifdef VEDIC_SIGNED_EN
   assign w_aIn   = (io_bus.sign_mode && io_bus.a[WIDTH-1]) ? (~io_bus.a + 1'b1) : io_bus.a;
   assign w_bIn   = (io_bus.sign_mode && io_bus.b[WIDTH-1]) ? (~io_bus.b + 1'b1) : io_bus.b;
   assign w_negIn = io_bus.sign_mode && (io_bus.a[WIDTH-1] ^ io_bus.b[WIDTH-1]);
`else
   assign w_aIn   = io_bus.a;
   assign w_bIn   = io_bus.b;
   assign w_negIn = 1'b0;
`endif

   // Stage 1: capture operands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1   <= 1'b0;
         r_a    <= '0;
         r_b    <= '0;
         r_neg1 <= 1'b0;
      end else if (w_en) begin
         r_v1   <= io_bus.in_valid;
         r_a    <= w_aIn;
         r_b    <= w_bIn;
         r_neg1 <= w_negIn;
      end
   end

   vedic_nxn #(.N(HALF)) u_ll (.i_a(r_a[HALF-1:0]),     .i_b(r_b[HALF-1:0]),     .o_p(w_ll));
   vedic_nxn #(.N(HALF)) u_lh (.i_a(r_a[HALF-1:0]),     .i_b(r_b[WIDTH-1:HALF]), .o_p(w_lh));
   vedic_nxn #(.N(HALF)) u_hl (.i_a(r_a[WIDTH-1:HALF]), .i_b(r_b[HALF-1:0]),     .o_p(w_hl));
   vedic_nxn #(.N(HALF)) u_hh (.i_a(r_a[WIDTH-1:HALF]), .i_b(r_b[WIDTH-1:HALF]), .o_p(w_hh));

   // Stage 2: register the four partial products.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v2   <= 1'b0;
         r_ll   <= '0;
         r_lh   <= '0;
         r_hl   <= '0;
         r_hh   <= '0;
         r_neg2 <= 1'b0;
      end else if (w_en) begin
         r_v2   <= r_v1;
         r_ll   <= w_ll;
         r_lh   <= w_lh;
         r_hl   <= w_hl;
         r_hh   <= w_hh;
         r_neg2 <= r_neg1;
      end
   end

   // Recombination; the cross sum is one bit wider so its carry lands in the top half.
   assign w_mid  = {1'b0, r_lh} + {1'b0, r_hl};
   assign w_prod = {r_hh, r_ll} + ({{(WIDTH-1){1'b0}}, w_mid} << HALF);
   assign w_y    = r_neg2 ? (~w_prod + 1'b1) : w_prod;

   // Stage 3: product register feeding the output handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v3 <= 1'b0;
         r_y  <= '0;
      end else if (w_en) begin
         r_v3 <= r_v2;
         r_y  <= w_y;
      end
   end

   assign io_bus.out_valid = r_v3;
   assign io_bus.y         = r_y;

endmodule

`default_nettype wire

// File: tb/tb_vedic_mult_pipe.sv
// tb_vedic_mult_pipe
// Drives four multiplier instances (WIDTH 8, 16, 32, 64) in lockstep from one
// 64-bit stimulus stream; each lane truncates the operands to its own width.
// A per-lane queue holds products predicted with plain arithmetic at accept
// time and is compared at each output transfer.
// Optional feature macro: VEDIC_SIGNED_EN (sign_mode driven and modelled)
`timescale 1ns/1ps

module tb_vedic_mult_pipe;
   import vedic_pkg::*;

`ifdef VEDIC_SIGNED_EN
   localparam bit SIGNED_BUILD = 1'b1;
`else
   localparam bit SIGNED_BUILD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        inValid = 1'b0;
   logic        outReady = 1'b0;
   logic [63:0] aStim = '0;
   logic [63:0] bStim = '0;
   logic        signMode = 1'b0;

   logic [3:0]  outValidV;
   logic [3:0]  inReadyV;
   logic [31:0] y16;

   int checkCount = 0;
   int passCount  = 0;

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
   endtask

   // Reference product from the arithmetic definition, per lane width.
   function automatic logic [127:0] expectedProduct(input logic [63:0] av, input logic [63:0] bv,
                                                    input int w, input bit sm);
      logic [127:0] mask, mask2, ua, ub, p;
      bit negA, negB;
      mask  = (128'd1 << w) - 128'd1;
      mask2 = (w == 64) ? {128{1'b1}} : ((128'd1 << (2 * w)) - 128'd1);
      ua = {64'd0, av} & mask;
      ub = {64'd0, bv} & mask;
      if (sm && SIGNED_BUILD) begin
         negA = ua[w-1];
         negB = ub[w-1];
         if (negA) ua = (~ua + 128'd1) & mask;
         if (negB) ub = (~ub + 128'd1) & mask;
         p = ua * ub;
         if (negA ^ negB) p = ~p + 128'd1;
      end else begin
         p = ua * ub;
      end
      return p & mask2;
   endfunction

   // Operand generator biased toward the corner values.
   function automatic logic [63:0] pickOperand();
      case ($urandom_range(0, 7))
         0: return 64'd0;
         1: return {64{1'b1}};
         2: return 64'd1;
         3: return 64'h8000_0000_8000_8080;
         default: return {$urandom(), $urandom()};
      endcase
   endfunction

   for (genvar g = 0; g < 4; g++) begin : lane
      localparam int W = 8 << g;

      vedic_mult_pipe_if #(.WIDTH(W)) bus ();

      vedic_mult_pipe #(.WIDTH(W)) dut (
         .clk    (clk),
         .rst_n  (rst_n),
         .io_bus (bus.slave)
      );

      assign bus.in_valid  = inValid;
      assign bus.out_ready = outReady;
      assign bus.a         = aStim[W-1:0];
      assign bus.b         = bStim[W-1:0];
`ifdef VEDIC_SIGNED_EN
      assign bus.sign_mode = signMode;
`endif
      assign outValidV[g]  = bus.out_valid;
      assign inReadyV[g]   = bus.in_ready;
      if (g == 1) begin : g_tap
         assign y16 = bus.y;
      end

      logic [127:0] expQ[$];
      logic [127:0] expv;
      logic [127:0] prevY;
      bit           prevHold = 1'b0;

      // Scoreboard: sampled mid-cycle, so values seen here are those the next edge acts on.
      always @(negedge clk) begin
         if (!rst_n) begin
            expQ.delete();
            prevHold = 1'b0;
         end else begin
            if (prevHold) begin
               checkOutput($sformatf("w%0d_holdValid", W), {127'd0, bus.out_valid}, 128'd1);
               checkOutput($sformatf("w%0d_holdY", W), {64'd0, bus.y}, prevY);
            end
            if (bus.out_valid && bus.out_ready) begin
               checkOutput($sformatf("w%0d_expected", W), {127'd0, expQ.size() != 0}, 128'd1);
               if (expQ.size() != 0) begin
                  expv = expQ.pop_front();
                  checkOutput($sformatf("w%0d_y", W), {64'd0, bus.y}, expv);
               end
            end
            if (bus.in_valid && bus.in_ready)
               expQ.push_back(expectedProduct(aStim, bStim, W, signMode));
            prevHold = bus.out_valid && !bus.out_ready;
            prevY    = {64'd0, bus.y};
         end
      end
   end

   // One cycle of inputs; returns 1 ns after the edge that consumed them.
   task automatic applyStimulus(input logic v, input logic [63:0] av, input logic [63:0] bv,
                                input logic sm, input logic ordy);
      inValid  = v;
      aStim    = av;
      bStim    = bv;
      signMode = sm;
      outReady = ordy;
      @(posedge clk);
      #1;
   endtask

   function automatic int pendingTotal();
      return lane[0].expQ.size() + lane[1].expQ.size() + lane[2].expQ.size() + lane[3].expQ.size();
   endfunction

   task automatic drainPipe();
      int budget;
      budget = 0;
      while (pendingTotal() != 0 && budget < 20) begin
         applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
         budget++;
      end
      checkOutput("drainEmpty", 128'(pendingTotal()), 128'd0);
   endtask

   function automatic logic randSign();
      return SIGNED_BUILD ? 1'($urandom_range(0, 1)) : 1'b0;
   endfunction

   logic [63:0] corners [5] = '{64'd0, 64'd1, {64{1'b1}}, 64'h8000_0000_0000_0000, 64'h8000_0000_8000_8080};
   logic [63:0] sgnA [4] = '{64'hFFFD, 64'h8000, 64'h8000, 64'hFFFF};
   logic [63:0] sgnB [4] = '{64'h0005, 64'h8000, 64'h8000, 64'h0002};
   logic        sgnM [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

   initial begin
      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rstOutValid", {124'd0, outValidV}, 128'd0);
      checkOutput("rstY16", {96'd0, y16}, 128'd0);
      rst_n = 1'b1;
      #1;
      checkOutput("rstInReady", {124'd0, inReadyV}, 128'hF);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);

      // Single transfer latency: valid appears exactly two edges after acceptance.
      applyStimulus(1'b1, {64{1'b1}}, {64{1'b1}}, 1'b0, 1'b1);
      for (int k = 0; k < VEDIC_LATENCY - 1; k++) begin
         checkOutput("latLow", {124'd0, outValidV}, 128'd0);
         applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
      end
      checkOutput("latHigh", {124'd0, outValidV}, 128'hF);
      checkOutput("latY16", {96'd0, y16}, 128'hFFFE0001);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
      checkOutput("latDrop", {124'd0, outValidV}, 128'd0);

      // Continuous stream: one product per cycle after the fill.
      for (int i = 0; i < 256; i++) begin
         applyStimulus(1'b1, pickOperand(), pickOperand(), randSign(), 1'b1);
         if (i >= VEDIC_LATENCY - 1)
            checkOutput("streamValid", {124'd0, outValidV}, 128'hF);
      end
      drainPipe();

      // Backpressure: fill, stall five cycles, then release with a new operand.
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, pickOperand(), pickOperand(), randSign(), 1'b0);
      for (int i = 0; i < 5; i++) begin
         checkOutput("stallInReady", {124'd0, inReadyV}, 128'd0);
         checkOutput("stallOutValid", {124'd0, outValidV}, 128'hF);
         applyStimulus(1'b1, pickOperand(), pickOperand(), randSign(), 1'b0);
      end
      checkOutput("stallInReadyEnd", {124'd0, inReadyV}, 128'd0);
      applyStimulus(1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1);
      applyStimulus(1'b1, pickOperand(), pickOperand(), randSign(), 1'b1);
      drainPipe();

      // Reset while every stage holds data.
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b1, pickOperand(), pickOperand(), randSign(), 1'b1);
      inValid = 1'b0;
      rst_n   = 1'b0;
      #1;
      checkOutput("midRstOutValid", {124'd0, outValidV}, 128'd0);
      checkOutput("midRstY16", {96'd0, y16}, 128'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(1'b1, 64'hDEAD_BEEF_CAFE_F00D, 64'h0000_0003_0000_0007, 1'b0, 1'b1);
      drainPipe();

      // Signed and unsigned interpretation of the same bit patterns.
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b1, sgnA[i], sgnB[i], sgnM[i], 1'b1);
      drainPipe();

      // Corner operands crossed.
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++)
            applyStimulus(1'b1, corners[i], corners[j], 1'b0, 1'b1);
      drainPipe();

      // Random valid and random downstream backpressure.
      for (int i = 0; i < 300; i++)
         applyStimulus(1'($urandom_range(0, 1)), pickOperand(), pickOperand(), randSign(),
                       1'($urandom_range(0, 3) != 0));
      drainPipe();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
